// File: rtl/dcache_pkg.sv
// dcache_pkg
// Shared definitions for the direct-mapped, write-back, write-allocate data
// cache: controller state encoding and the fixed address-split constants.
// The INDEX_W / TAG_W values here describe the default 16-line geometry;
// the RTL modules derive their own widths from their NUM_LINES parameter.
package dcache_pkg;

    // Controller states. GAP is the single idle cycle on the memory port
    // between a write-back and the following refill.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        GAP       = 2'd2,
        ALLOCATE  = 2'd3
    } dcacheState_e;

    localparam int OFFSET_W       = 5;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 8;
    localparam int NUM_LINES_DEF  = 16;
    localparam int INDEX_W        = $clog2(NUM_LINES_DEF);
    localparam int TAG_W          = 32 - INDEX_W - OFFSET_W;

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram
// Storage for the cache: per-line valid, dirty, tag and data.
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset (clears
//                       valid and dirty only; tag/data are not reset)
//   cpuIndex_i          read port A index (current CPU request)
//   cpuValid_o/cpuDirty_o/cpuTag_o/cpuLine_o   read port A contents
//   victimIndex_i       read port B index (line involved in the miss)
//   victimTag_o/victimLine_o                   read port B contents
//   wrIndex_i           write index shared by both write kinds
//   wordEn_i            store hit: replace one word, set dirty
//   fillEn_i            refill: replace line and tag, valid=1, dirty=0
//   wrWordSel_i/wrWord_i  word being stored
//   wrTag_i/wrLine_i      tag and line being refilled
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int LINE_BITS = 256,
    parameter int TAG_BITS  = 23,
    localparam int IDX_W    = $clog2(NUM_LINES),
    localparam int SEL_W    = $clog2(WORDS_PER_LINE)
)(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_W-1:0]     cpuIndex_i,
    output logic                 cpuValid_o,
    output logic                 cpuDirty_o,
    output logic [TAG_BITS-1:0]  cpuTag_o,
    output logic [LINE_BITS-1:0] cpuLine_o,
    input  logic [IDX_W-1:0]     victimIndex_i,
    output logic [TAG_BITS-1:0]  victimTag_o,
    output logic [LINE_BITS-1:0] victimLine_o,
    input  logic [IDX_W-1:0]     wrIndex_i,
    input  logic                 wordEn_i,
    input  logic                 fillEn_i,
    input  logic [SEL_W-1:0]     wrWordSel_i,
    input  logic [WORD_W-1:0]    wrWord_i,
    input  logic [TAG_BITS-1:0]  wrTag_i,
    input  logic [LINE_BITS-1:0] wrLine_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_BITS-1:0]  tagArray_q  [NUM_LINES];
    logic [LINE_BITS-1:0] dataArray_q [NUM_LINES];

    // Both read ports are purely combinational so hits resolve in the
    // same cycle as the request.
    assign cpuValid_o   = valid_q[cpuIndex_i];
    assign cpuDirty_o   = dirty_q[cpuIndex_i];
    assign cpuTag_o     = tagArray_q[cpuIndex_i];
    assign cpuLine_o    = dataArray_q[cpuIndex_i];
    assign victimTag_o  = tagArray_q[victimIndex_i];
    assign victimLine_o = dataArray_q[victimIndex_i];

    // Status bits: reset wins, then a refill (fresh clean line), then a
    // store hit marking the line dirty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fillEn_i) begin
            valid_q[wrIndex_i] <= 1'b1;
            dirty_q[wrIndex_i] <= 1'b0;
        end else if (wordEn_i) begin
            dirty_q[wrIndex_i] <= 1'b1;
        end
    end

    // Tag and data arrays have no reset; a line is only trusted once its
    // valid bit is set by a refill.
    always_ff @(posedge clk_i) begin
        if (fillEn_i) begin
            tagArray_q[wrIndex_i]  <= wrTag_i;
            dataArray_q[wrIndex_i] <= wrLine_i;
        end else if (wordEn_i) begin
            dataArray_q[wrIndex_i][int'(wrWordSel_i)*WORD_W +: WORD_W] <= wrWord_i;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller
// Direct-mapped write-back / write-allocate data cache for the MEM stage.
// Hits are answered combinationally; misses stall the pipeline while an
// optional dirty write-back and a line refill run over a req/ack port.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   cpu_addr_i, cpu_data_i        byte address and store data
//   cpu_MemRead_i, cpu_MemWrite_i load / store request (both = store)
//   cpu_data_o                    load data on a read hit, else 0
//   cpu_stall_o                   freeze the pipeline
//   mem_addr_o, mem_data_o        line address and write-back line
//   mem_enable_o, mem_write_o     memory request, 1 = write-back
//   mem_data_i, mem_ack_i         refill line and one-cycle completion
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int LINE_BITS = 256,
    parameter int ADDR_W    = 32
)(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    input  logic [WORD_W-1:0]    cpu_data_i,
    input  logic                 cpu_MemRead_i,
    input  logic                 cpu_MemWrite_i,
    output logic [WORD_W-1:0]    cpu_data_o,
    output logic                 cpu_stall_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAGB_W = ADDR_W - IDX_W - OFFSET_W;
    localparam int SEL_W  = $clog2(WORDS_PER_LINE);

    dcacheState_e      state_q, state_d;
    logic [IDX_W-1:0]  missIndex_q, missIndex_d;
    logic [TAGB_W-1:0] missTag_q, missTag_d;

    logic [IDX_W-1:0]     cpuIndex;
    logic [TAGB_W-1:0]    cpuTag;
    logic [SEL_W-1:0]     cpuWordSel;
    logic [1:0]           unusedByteBits;
    logic                 cpuValid, cpuDirty;
    logic [TAGB_W-1:0]    cpuTagRd, victimTag;
    logic [LINE_BITS-1:0] cpuLine, victimLine;
    logic                 request, hit, readHit;
    logic                 wordEn, fillEn;
    logic [IDX_W-1:0]     wrIndex;

    assign cpuIndex       = cpu_addr_i[OFFSET_W +: IDX_W];
    assign cpuTag         = cpu_addr_i[ADDR_W-1 -: TAGB_W];
    assign cpuWordSel     = cpu_addr_i[2 +: SEL_W];
    assign unusedByteBits = cpu_addr_i[1:0];

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .LINE_BITS (LINE_BITS),
        .TAG_BITS  (TAGB_W)
    ) sramInst (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cpuIndex_i    (cpuIndex),
        .cpuValid_o    (cpuValid),
        .cpuDirty_o    (cpuDirty),
        .cpuTag_o      (cpuTagRd),
        .cpuLine_o     (cpuLine),
        .victimIndex_i (missIndex_q),
        .victimTag_o   (victimTag),
        .victimLine_o  (victimLine),
        .wrIndex_i     (wrIndex),
        .wordEn_i      (wordEn),
        .fillEn_i      (fillEn),
        .wrWordSel_i   (cpuWordSel),
        .wrWord_i      (cpu_data_i),
        .wrTag_i       (missTag_q),
        .wrLine_i      (mem_data_i)
    );

    // Hit detection and CPU-side outputs. A store wins when both request
    // lines are high, so read data is only presented for pure loads.
    always_comb begin
        request     = cpu_MemRead_i | cpu_MemWrite_i;
        hit         = request && cpuValid && (cpuTagRd == cpuTag);
        readHit     = hit && cpu_MemRead_i && !cpu_MemWrite_i;
        cpu_data_o  = readHit ? cpuLine[int'(cpuWordSel)*WORD_W +: WORD_W] : '0;
        cpu_stall_o = (state_q == IDLE) ? (request && !hit) : 1'b1;
    end

    // Array write enables. Store hits retire only in IDLE; the refill
    // lands on the ack edge of ALLOCATE. Neither is allowed under reset.
    always_comb begin
        wordEn  = (state_q == IDLE) && cpu_MemWrite_i && hit && !rst_i;
        fillEn  = (state_q == ALLOCATE) && mem_ack_i && !rst_i;
        wrIndex = fillEn ? missIndex_q : cpuIndex;
    end

    // Miss sequencing. The missing address is captured on entry so the
    // transaction completes even if the MEM stage drops or changes its
    // request mid-miss. Acks outside WRITEBACK/ALLOCATE are ignored.
    always_comb begin
        state_d     = state_q;
        missIndex_d = missIndex_q;
        missTag_d   = missTag_q;
        case (state_q)
            IDLE: begin
                if (request && !hit) begin
                    missIndex_d = cpuIndex;
                    missTag_d   = cpuTag;
                    state_d     = (cpuValid && cpuDirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: if (mem_ack_i) state_d = GAP;
            GAP:       state_d = ALLOCATE;
            ALLOCATE:  if (mem_ack_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            missIndex_q <= '0;
            missTag_q   <= '0;
        end else begin
            state_q     <= state_d;
            missIndex_q <= missIndex_d;
            missTag_q   <= missTag_d;
        end
    end

    // Memory port muxing. Address and data are driven to zero whenever no
    // request is outstanding so the port reads as quiet in IDLE and GAP.
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_q)
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {victimTag, missIndex_q, {OFFSET_W{1'b0}}};
                mem_data_o   = victimLine;
            end
            ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {missTag_q, missIndex_q, {OFFSET_W{1'b0}}};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller
// Directed bench for dcache_controller. Memory returns a fixed pattern per
// word (word content = word address ^ 32'hA5A5_0000) and acks in the
// Nth enable cycle, N set by ackLatency.
module tb_dcache_controller;
    import dcache_pkg::*;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  cpuAddr = '0;
    logic [31:0]  cpuWData = '0;
    logic         cpuRead = 1'b0;
    logic         cpuWrite = 1'b0;
    logic [31:0]  cpuRData;
    logic         cpuStall;
    logic [31:0]  memAddr;
    logic [255:0] memWData;
    logic         memEnable;
    logic         memWrite;
    logic [255:0] memRData = '0;
    logic         modelAck = 1'b0;
    logic         strayAck = 1'b0;
    logic         memAck;

    int testsRun = 0;
    int testsFailed = 0;
    int ackLatency = 10;
    int enableCount = 0;

    assign memAck = modelAck | strayAck;

    dcache_controller dut (
        .clk_i          (clock),
        .rst_i          (reset),
        .cpu_addr_i     (cpuAddr),
        .cpu_data_i     (cpuWData),
        .cpu_MemRead_i  (cpuRead),
        .cpu_MemWrite_i (cpuWrite),
        .cpu_data_o     (cpuRData),
        .cpu_stall_o    (cpuStall),
        .mem_addr_o     (memAddr),
        .mem_data_o     (memWData),
        .mem_enable_o   (memEnable),
        .mem_write_o    (memWrite),
        .mem_data_i     (memRData),
        .mem_ack_i      (memAck)
    );

    always #5 clock = ~clock;

    function automatic logic [255:0] refillLine(input logic [31:0] lineAddr);
        logic [255:0] line;
        for (int i = 0; i < 8; i++) begin
            line[i*32 +: 32] = (lineAddr + 32'(i*4)) ^ 32'hA5A5_0000;
        end
        return line;
    endfunction

    // Memory model: counts consecutive enable cycles and pulses ack in the
    // ackLatency-th one. Dropping enable abandons the request.
    always @(negedge clock) begin
        if (memEnable) begin
            enableCount = enableCount + 1;
            if (enableCount == ackLatency) begin
                modelAck    = 1'b1;
                memRData    = refillLine(memAddr);
                enableCount = 0;
            end else begin
                modelAck = 1'b0;
            end
        end else begin
            enableCount = 0;
            modelAck    = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data);
        cpuRead  = rd;
        cpuWrite = wr;
        cpuAddr  = addr;
        cpuWData = data;
    endtask

    task automatic nextCycle();
        @(negedge clock);
    endtask

    // Walks a stalled sequence from the current sample point until stall
    // drops, recording what the memory port showed along the way.
    task automatic runMiss(output int stallCycles, output logic [31:0] wbAddr,
                           output logic [255:0] wbData, output logic [31:0] allocAddr,
                           output int gapCycles);
        logic wbSeen;
        stallCycles = 0;
        wbSeen      = 1'b0;
        wbAddr      = '0;
        wbData      = '0;
        allocAddr   = '0;
        gapCycles   = 0;
        while (cpuStall && stallCycles < 200) begin
            stallCycles++;
            if (memEnable && memWrite && !wbSeen) begin
                wbSeen = 1'b1;
                wbAddr = memAddr;
                wbData = memWData;
            end else if (memEnable && !memWrite) begin
                allocAddr = memAddr;
            end else if (!memEnable && wbSeen) begin
                gapCycles++;
            end
            @(negedge clock);
            #1;
        end
        if (stallCycles >= 200) checkOutput("missTimeout", 256'(cpuStall), 256'(0));
    endtask

    int           stallN, gapN;
    logic [31:0]  wbA, allocA;
    logic [255:0] wbD, expLine;

    initial begin
        // Reset state
        nextCycle(); nextCycle(); #1;
        checkOutput("rstStall", 256'(cpuStall), 256'(0));
        checkOutput("rstEnable", 256'(memEnable), 256'(0));
        checkOutput("rstWrite", 256'(memWrite), 256'(0));
        checkOutput("rstAddr", 256'(memAddr), 256'(0));
        checkOutput("rstData", memWData, 256'(0));
        checkOutput("rstCpuData", 256'(cpuRData), 256'(0));

        // Clean read miss, ack in 10th enable cycle
        nextCycle();
        reset = 1'b0;
        ackLatency = 10;
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
        #1;
        runMiss(stallN, wbA, wbD, allocA, gapN);
        checkOutput("cleanStall", 256'(stallN), 256'(11));
        checkOutput("cleanAllocAddr", 256'(allocA), 256'(32'h40));
        checkOutput("cleanNoWb", 256'(wbA), 256'(0));
        checkOutput("cleanData", 256'(cpuRData), 256'(32'hA5A5_0040));

        // Store hit and zero-latency read-back
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF);
        #1;
        checkOutput("storeHitStall", 256'(cpuStall), 256'(0));
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h44, 32'h0);
        #1;
        checkOutput("dirtyAfterStore", 256'(dut.sramInst.dirty_q[2]), 256'(1));
        checkOutput("readBackStall", 256'(cpuStall), 256'(0));
        checkOutput("readBackData", 256'(cpuRData), 256'(32'hDEAD_BEEF));

        // Conflict miss on a dirty line
        nextCycle();
        ackLatency = 3;
        applyStimulus(1'b1, 1'b0, 32'h240, 32'h0);
        #1;
        runMiss(stallN, wbA, wbD, allocA, gapN);
        expLine = refillLine(32'h40);
        expLine[63:32] = 32'hDEAD_BEEF;
        checkOutput("dirtyStall", 256'(stallN), 256'(8));
        checkOutput("wbAddr", 256'(wbA), 256'(32'h40));
        checkOutput("wbData", wbD, expLine);
        checkOutput("gapCycles", 256'(gapN), 256'(1));
        checkOutput("dirtyAllocAddr", 256'(allocA), 256'(32'h240));
        checkOutput("dirtyData", 256'(cpuRData), 256'(32'hA5A5_0240));

        // Store miss on an empty line, then a conflicting read
        nextCycle();
        ackLatency = 2;
        applyStimulus(1'b0, 1'b1, 32'h80, 32'h1234_5678);
        #1;
        runMiss(stallN, wbA, wbD, allocA, gapN);
        checkOutput("storeMissStall", 256'(stallN), 256'(3));
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("storeMissDirty", 256'(dut.sramInst.dirty_q[4]), 256'(1));
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h80, 32'h0);
        #1;
        checkOutput("storeMissData", 256'(cpuRData), 256'(32'h1234_5678));
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h280, 32'h0);
        #1;
        runMiss(stallN, wbA, wbD, allocA, gapN);
        expLine = refillLine(32'h80);
        expLine[31:0] = 32'h1234_5678;
        checkOutput("conflictStall", 256'(stallN), 256'(6));
        checkOutput("conflictWbAddr", 256'(wbA), 256'(32'h80));
        checkOutput("conflictWbData", wbD, expLine);
        checkOutput("conflictAlloc", 256'(allocA), 256'(32'h280));

        // Stray ack in IDLE is ignored
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        strayAck = 1'b1;
        nextCycle();
        strayAck = 1'b0;
        #1;
        checkOutput("strayAckState", 256'(dut.state_q), 256'(IDLE));
        checkOutput("strayAckEnable", 256'(memEnable), 256'(0));

        // Reset in the 3rd ALLOCATE cycle
        nextCycle();
        ackLatency = 10;
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h0);
        nextCycle();
        nextCycle();
        nextCycle();
        reset = 1'b1;
        #1;
        checkOutput("abortEnableBefore", 256'(memEnable), 256'(1));
        nextCycle();
        reset = 1'b0;
        ackLatency = 2;
        #1;
        checkOutput("abortEnable", 256'(memEnable), 256'(0));
        checkOutput("abortState", 256'(dut.state_q), 256'(IDLE));
        checkOutput("abortValid", 256'(dut.sramInst.valid_q), 256'(0));
        checkOutput("abortMissAgain", 256'(cpuStall), 256'(1));
        runMiss(stallN, wbA, wbD, allocA, gapN);
        checkOutput("abortRefillStall", 256'(stallN), 256'(3));
        checkOutput("abortRefillData", 256'(cpuRData), 256'(32'hA5A5_0300));

        // Request dropped in the 2nd ALLOCATE cycle
        nextCycle();
        ackLatency = 4;
        applyStimulus(1'b1, 1'b0, 32'h500, 32'h0);
        #1;
        checkOutput("flushMissStall", 256'(cpuStall), 256'(1));
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("flushHeld", 256'(cpuStall), 256'(1));
        runMiss(stallN, wbA, wbD, allocA, gapN);
        checkOutput("flushRemaining", 256'(stallN), 256'(3));
        checkOutput("flushAlloc", 256'(allocA), 256'(32'h500));
        checkOutput("flushValid", 256'(dut.sramInst.valid_q[8]), 256'(1));
        checkOutput("flushState", 256'(dut.state_q), 256'(IDLE));
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h500, 32'h0);
        #1;
        checkOutput("flushHitStall", 256'(cpuStall), 256'(0));
        checkOutput("flushHitData", 256'(cpuRData), 256'(32'hA5A5_0500));

        // Read and write together behave as a store
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h504, 32'h0BAD_F00D);
        #1;
        checkOutput("bothStall", 256'(cpuStall), 256'(0));
        checkOutput("bothNoReadData", 256'(cpuRData), 256'(0));
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h504, 32'h0);
        #1;
        checkOutput("bothReadBack", 256'(cpuRData), 256'(32'h0BAD_F00D));

        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data-cache controller serving the MEM stage of the pipelined CPU. Answers the MEM stage's MemRead/MemWrite requests on a hit in the same cycle. On a miss it holds the pipeline through `cpu_stall_o`, writes back a dirty victim line, and refills the line from data memory over a req/ack handshake. It is the responder for the memory accesses whose load-use hazards are resolved upstream in ID.

## Interface
Parameters:
- `NUM_LINES`, 16 — cache lines; power of two.
- `LINE_BITS`, 256 — line width (32 bytes, 8 words).
- `ADDR_W`, 32 — byte address width.

Ports:
- `clk_i`  in  1  — single clock, all state on rising edge.
- `rst_i`  in  1  — synchronous, active-high reset.
- `cpu_addr_i`  in  32  — byte address from MEM stage.
- `cpu_data_i`  in  32  — store data.
- `cpu_MemRead_i`  in  1  — load request.
- `cpu_MemWrite_i`  in  1  — store request.
- `cpu_data_o`  out  32  — load data, valid when request and not stalled.
- `cpu_stall_o`  out  1  — freeze PC and all pipeline registers.
- `mem_addr_o`  out  32  — line-aligned memory address.
- `mem_data_o`  out  256  — write-back line.
- `mem_enable_o`  out  1  — memory request, held until ack.
- `mem_write_o`  out  1  — 1 = write-back, 0 = refill.
- `mem_data_i`  in  256  — refill line, valid in ack cycle.
- `mem_ack_i`  in  1  — one-cycle completion pulse.

## Operation
- Address split: offset `[4:0]`, word select `[4:2]`, index `[8:5]`, tag `[31:9]` (23 bits).
- Per line: valid, dirty, tag, 256-bit data.
- Hit = request && valid[index] && tag match.
- Request = MemRead | MemWrite. If both are asserted, it is treated as a write.
- Read hit: `cpu_data_o` = selected word, combinational.
- Write hit: selected word is replaced at the clock edge and dirty is set. No stall.
- `cpu_stall_o` = request && !hit in IDLE; 1 in every other state.
- FSM states (package enum): IDLE, WRITEBACK, GAP, ALLOCATE.
  - IDLE → WRITEBACK: miss and victim is valid and dirty.
  - IDLE → ALLOCATE: miss and victim is clean or invalid.
  - WRITEBACK: `mem_enable_o`=1, `mem_write_o`=1, `mem_addr_o`={victim tag, index, 5'b0}, `mem_data_o`=victim line. On ack → GAP.
  - GAP: `mem_enable_o`=0 for exactly one cycle → ALLOCATE.
  - ALLOCATE: `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o`={tag, index, 5'b0}. On the ack edge: line ← `mem_data_i`, valid=1, dirty=0, tag written → IDLE.
- Store miss: the refill completes first, then the store retires as a write hit in IDLE (sets dirty).
- Request dropped mid-miss (flush): the transaction completes anyway, state returns to IDLE, stall then follows the new inputs.
- `mem_enable_o` is 0 in IDLE and GAP. `mem_write_o` and `mem_data_o` are don't-care when enable is 0.

## Timing
- Reset values:
  - state=IDLE; all valid and dirty bits=0.
  - `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0.
  - `cpu_data_o`=0 when there is no read hit.
  - Tag and data arrays are not reset.
- `cpu_stall_o` is combinational and is 0 during reset when there is no request.
- Reset mid-miss: returns to IDLE next edge with `mem_enable_o`=0. The memory model must accept an abandoned request.
- Hit latency is 0 cycles.
- Clean miss: stall cycles = 1 + N, where N is the number of ALLOCATE cycles including the ack cycle.
- Dirty miss: stall cycles = 1 + W + 1 + N, where W is the number of WRITEBACK cycles including the ack cycle.
- An ack seen in IDLE or GAP is ignored.
- Only one outstanding memory transaction at a time.

## Structure
- `dcache_pkg`:
  - state enum.
  - `OFFSET_W`=5, `INDEX_W`=$clog2(NUM_LINES), `TAG_W`=ADDR_W-INDEX_W-5.
  - `WORDS_PER_LINE`=8.
- Sub-module `dcache_sram`: tag, valid, dirty and data arrays.
  - Combinational read.
  - Single write port with word-enable (store hit) or full-line write (refill).
  - Synchronous clear of valid and dirty on `rst_i`.
- The controller holds the FSM, hit logic and memory-port muxing.

## Test plan
- Reset, then read 0x0000_0040 with memory acking in the 10th enable cycle:
  - stall high 11 cycles, `mem_addr_o`=0x40, `mem_write_o`=0.
  - Cycle 12: stall=0, `cpu_data_o`=word 0 of refill line.
- Store 0xDEADBEEF to 0x44 after the fill: no stall, dirty set. A following read of 0x44 returns 0xDEADBEEF with zero latency.
- Read 0x0000_0240 (same index 2, different tag) while the line is dirty:
  - WRITEBACK to 0x40 carrying the line with 0xDEADBEEF in word 1.
  - One GAP cycle with enable=0.
  - ALLOCATE to 0x240; stall drops the cycle after the second ack.
- Store miss to 0x80 on a clean line: refill then write. Dirty=1 after retire. A later conflict to 0x280 causes a write-back to 0x80.
- Assert `rst_i` in the 3rd ALLOCATE cycle: next cycle `mem_enable_o`=0, state IDLE, and a read of the same address misses again.
- Drop MemRead in the 2nd ALLOCATE cycle: the refill still completes, valid=1, and stall=0 once back in IDLE.
